// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 master for fixed 10-bit frames: one SETUP half-period, 20 SCLK
// half-periods of shifting, then a single-cycle DONE with the received word.
module spi_frame_ctrl #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [9:0] tx_data_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       cs_n_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [9:0] rx_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
  localparam logic [3:0] LAST_BIT  = 4'd10;

  state_t     state_q;
  logic [9:0] tx_sr_q;
  logic [9:0] rx_sr_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] half_cnt_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       cs_n_q;
  logic       busy_q;
  logic       done_q;
  logic [9:0] rx_data_q;
  logic       half_end_s;

  assign half_end_s = (half_cnt_q == HALF_LAST);

  // Frame sequencer; every output is driven straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= 10'h000;
      rx_sr_q    <= 10'h000;
      bit_cnt_q  <= 4'd0;
      half_cnt_q <= 8'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= 10'h000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            tx_sr_q    <= tx_data_i;
            rx_sr_q    <= 10'h000;
            bit_cnt_q  <= 4'd0;
            half_cnt_q <= 8'd0;
            mosi_q     <= tx_data_i[9];
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SETUP;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          // The end of SETUP is also the first SCLK rising edge.
          if (half_end_s) begin
            half_cnt_q <= 8'd0;
            sclk_q     <= 1'b1;
            rx_sr_q    <= {rx_sr_q[8:0], miso_i};
            bit_cnt_q  <= 4'd1;
            state_q    <= SHIFT;
          end else begin
            half_cnt_q <= half_cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (!half_end_s) begin
            half_cnt_q <= half_cnt_q + 8'd1;
          end else begin
            half_cnt_q <= 8'd0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              // Rotating keeps every bit of the register in use; bit 0 is never re-sent.
              if (bit_cnt_q != LAST_BIT) begin
                tx_sr_q <= {tx_sr_q[8:0], tx_sr_q[9]};
                mosi_q  <= tx_sr_q[8];
              end else begin
                mosi_q <= mosi_q;
              end
            end else if (bit_cnt_q == LAST_BIT) begin
              mosi_q    <= 1'b0;
              cs_n_q    <= 1'b1;
              done_q    <= 1'b1;
              rx_data_q <= rx_sr_q;
              state_q   <= DONE;
            end else begin
              sclk_q    <= 1'b1;
              rx_sr_q   <= {rx_sr_q[8:0], miso_i};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameter HALF_DIV, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  frame request; sampled only in IDLE.
REQ-005 tx_data  input  10  frame to transmit, MSB first; captured on the start-accept edge.
REQ-006 miso  input  1  serial data from the slave.
REQ-007 sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-008 mosi  output  1  serial data to the slave.
REQ-009 cs_n  output  1  chip select, active-low.
REQ-010 busy  output  1  high from the cycle after start accept through the done cycle, inclusive.
REQ-011 done  output  1  one-cycle pulse at frame end.
REQ-012 rx_data  output  10  last received frame, MSB first; held until the next done.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SETUP, SHIFT and DONE.
REQ-014 IDLE: when start=1, the block SHALL copy tx_data into a 10-bit shift register, clear the bit counter, clear the half-period counter, enter SETUP and set cs_n=0 and busy=1 from the next cycle.
REQ-015 SETUP SHALL last HALF_DIV cycles with sclk=0 and mosi=shift register bit 9, then enter SHIFT.
REQ-016 SHIFT SHALL toggle sclk every HALF_DIV cycles, giving 20 half-periods.
REQ-017 On each sclk rising edge, the block SHALL sample miso into a separate 10-bit receive register, shifting left with miso entering bit 0.
REQ-018 On each sclk falling edge except the 10th, the block SHALL shift the transmit register left so that mosi presents the next bit.
REQ-019 A 4-bit counter SHALL count rising edges from 0 to 10; the counter SHALL NOT wrap.
REQ-020 After the 10th falling edge, the block SHALL enter DONE with sclk=0.
REQ-021 DONE SHALL last exactly one cycle, with done=1, cs_n=1, rx_data loaded from the receive register, and SHALL return to IDLE.
REQ-022 Total latency SHALL be 21*HALF_DIV cycles from the start-accept edge to the edge that asserts done.
REQ-023 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-024 A new start accepted in the IDLE cycle immediately after DONE SHALL begin a frame, so back-to-back frames are separated by at least one cs_n=1 cycle.
REQ-025 Changes to tx_data after start accept SHALL NOT affect the frame in progress.
REQ-026 In IDLE: sclk=0, mosi=0, cs_n=1, busy=0, done=0.
REQ-027 sclk, mosi, cs_n, busy and done SHALL be registered outputs.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0, and clear all counters and shift registers.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse and no rx_data update.
REQ-030 After rst deasserts, the first start SHALL begin a clean frame.

Verification
REQ-031 HALF_DIV=4, tx_data=10'h2A5, miso looped to mosi, single start pulse -> exactly 10 sclk rising edges, mosi bit sequence 1,0,1,0,1,0,0,1,0,1, done at cycle 84 after accept, rx_data=10'h2A5, cs_n=1 in the done cycle.
REQ-032 miso held at 1, tx_data=0 -> rx_data=10'h3FF and mosi=0 throughout; miso held at 0 -> rx_data=10'h000.
REQ-033 start pulsed at cycles 5, 40 and 83 of a frame -> no extra frame, a single done, and sclk period unchanged at 8 cycles.
REQ-034 start held high continuously -> back-to-back frames, each separated by exactly one IDLE cycle with cs_n=1 and one DONE cycle, i.e. cs_n high for 2 cycles between frames.
REQ-035 rst asserted after the 6th sclk rising edge -> cs_n=1 and sclk=0 immediately, no done, rx_data=0; next start gives a correct full frame.
REQ-036 HALF_DIV=2 with tx_data=10'h155 -> sclk period of 4 cycles, done at cycle 42, rx_data equal to the looped-back frame.
